// File: rtl/digit_serial_addsub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed CHUNK bits per clock,
// with the inter-chunk carry held in a register and valid/ready handshakes on both sides.

module dsas_chunk_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ci,
  output logic [W-1:0] o_s,
  output logic         o_co,
  output logic         o_cmsb
);
  assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};
  // carry into the top bit recovered from the sum bit, feeds the overflow flag
  assign o_cmsb = i_a[W-1] ^ i_b[W-1] ^ o_s[W-1];
endmodule

module digit_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c0,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c,
  output logic             o_ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(NCHUNK) + 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("digit_serial_addsub: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_s;
  logic               r_cy, r_c, r_ovf;

  logic [CHUNK-1:0]   w_ca, w_cb, w_sum;
  logic               w_co, w_cmsb, w_last;

  assign w_ca   = CHUNK'(r_a >> (r_cnt * CHUNK));
  assign w_cb   = CHUNK'(r_b >> (r_cnt * CHUNK));
  assign w_last = (r_cnt == CNT_W'(NCHUNK - 1));

  dsas_chunk_add #(.W(CHUNK)) u_add (
    .i_a    (w_ca),
    .i_b    (w_cb),
    .i_ci   (r_cy),
    .o_s    (w_sum),
    .o_co   (w_co),
    .o_cmsb (w_cmsb)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_next = S_BUSY;
      end
      S_BUSY: if (w_last) w_next = S_DONE;
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // subtract is folded in at accept time: a + ~b + ~c0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_s   <= '0;
      r_cy  <= 1'b0;
      r_c   <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_in_valid) begin
          r_a   <= i_a;
          r_b   <= i_b ^ {WIDTH{i_sub}};
          r_cy  <= i_c0 ^ i_sub;
          r_s   <= '0;
          r_c   <= 1'b0;
          r_ovf <= 1'b0;
          r_cnt <= '0;
        end
        S_BUSY: begin
          r_s[r_cnt*CHUNK +: CHUNK] <= w_sum;
          r_cy  <= w_co;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_c   <= w_co;
            r_ovf <= w_cmsb ^ w_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_s   = r_s;
  assign o_c   = r_c;
  assign o_ovf = r_ovf;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench for digit_serial_addsub (WIDTH=32, CHUNK=8): driver pushes expected
// results, a negedge monitor pops and compares on each output handshake.
module tb_digit_serial_addsub;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
    int               acc;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a, b;
    logic             c0, sub;
    logic [WIDTH-1:0] s;
    logic             c, ovf;
  } vec_t;

  logic             clk, rst_n, in_valid, in_ready, c0, sub, out_valid, out_ready, c, ovf;
  logic [WIDTH-1:0] a, b, s;
  int               cyc, n_tot, n_pass, mode;
  exp_t             q[$];
  vec_t             vecs[7];
  logic             prev_ov;

  digit_serial_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_c0(c0), .i_sub(sub), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_s(s), .o_c(c), .o_ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // whole-word reference with the overflow taken from operand/result signs
  function automatic exp_t model(input logic [WIDTH-1:0] ta, tb, input logic tc0, tsub);
    exp_t e;
    logic [WIDTH-1:0] bb;
    bb = tsub ? ~tb : tb;
    {e.c, e.s} = {1'b0, ta} + {1'b0, bb} + {{WIDTH{1'b0}}, tc0 ^ tsub};
    e.ovf = (ta[WIDTH-1] == bb[WIDTH-1]) && (e.s[WIDTH-1] != ta[WIDTH-1]);
    e.acc = 0;
    return e;
  endfunction

  // out_ready policy: 0 = always ready, 1 = hold off, 2 = random stalls
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_ov = 1'b0;
      else begin
        if (out_valid && !prev_ov) begin
          if (q.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'd0);
          else chk("latency", 64'(cyc - q[0].acc), 64'(NCHUNK));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("unexpected_result", 64'(out_valid), 64'd0);
          else begin
            exp_t e;
            e = q.pop_front();
            chk("s", 64'(s), 64'(e.s));
            chk("c", 64'(c), 64'(e.c));
            chk("ovf", 64'(ovf), 64'(e.ovf));
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic do_op(input vec_t v);
    int   k;
    exp_t e;
    k = 0;
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    if (!in_ready) begin chk("in_ready_timeout", 64'(in_ready), 64'd1); return; end
    a = v.a; b = v.b; c0 = v.c0; sub = v.sub; in_valid = 1'b1;
    e.s = v.s; e.c = v.c; e.ovf = v.ovf; e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 2000) begin @(negedge clk); k++; end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic wait_ov();
    int k;
    k = 0;
    while (!out_valid && k < 200) begin @(negedge clk); k++; end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  initial begin
    n_tot = 0; n_pass = 0; mode = 0;
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; c0 = 1'b0; sub = 1'b0;
    //         a             b             c0    sub   s             c     ovf
    vecs[0] = '{32'h02EB02EB, 32'h555502EB, 1'b0, 1'b0, 32'h584005D6, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_c", 64'(c), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) do_op(vecs[i]);
    drain();

    // result held under backpressure while new operands are offered
    mode = 1;
    do_op(vecs[2]);
    wait_ov();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; c0 = 1'b1; sub = 1'b1;
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_s", 64'(s), 64'h80000000);
      chk("hold_c", 64'(c), 64'd0);
      chk("hold_ovf", 64'(ovf), 64'd1);
    end
    in_valid = 1'b0;
    mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    do_op(vecs[0]);
    drain();

    // abort mid-operation with cnt=2
    do_op(vecs[1]);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_s", 64'(s), 64'd0);
    chk("abort_c", 64'(c), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    do_op(vecs[0]);
    drain();

    // random operands with random consumer stalls
    mode = 2;
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      exp_t e;
      v.a = $urandom; v.b = $urandom; v.c0 = 1'($urandom_range(0, 1)); v.sub = 1'($urandom_range(0, 1));
      if (i < 4) v.b = ~v.a;
      e = model(v.a, v.b, v.c0, v.sub);
      v.s = e.s; v.c = e.c; v.ovf = e.ovf;
      do_op(v);
    end
    drain();
    mode = 0;

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
